// File: rtl/ifq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ifq_pkg : shared types and constants for the instruction fetch queue       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package ifq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } ifq_state_t;

  localparam logic [5:0]  OP_J    = 6'b000010;
  localparam logic [31:0] PC_STEP = 32'd4;

  // J-format target: region bits come from the address of the following word
  function automatic logic [31:0] jump_target(input logic [31:0] pc, input logic [25:0] jidx);
    return ((pc + PC_STEP) & 32'hF000_0000) | {4'h0, jidx, 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ifq_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ifq_if : imem request/response and decode hand-off bundle                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface ifq_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc,
    input  imem_rvalid, imem_rdata, inst_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc,
    output imem_rvalid, imem_rdata, inst_ready, redirect, redirect_pc
  );
endinterface
`default_nettype wire

// File: rtl/ifq_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ifq_fifo : small power-of-2 FIFO of {pc, inst} entries with flush          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ifq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  input  wire logic                     i_push,
  input  wire logic                     i_pop,
  input  wire logic                     i_flush,
  input  wire logic [WIDTH-1:0]         i_data,
  output logic      [WIDTH-1:0]         o_data,
  output logic      [$clog2(DEPTH):0]   o_count,
  output logic                          o_full,
  output logic                          o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule
`default_nettype wire

// File: rtl/inst_fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | inst_fetch_queue : fetch PC owner, single-outstanding imem reader, queue   |
// | Optional macro IFQ_JUMP_PREDECODE_EN follows j words during fetch.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module inst_fetch_queue
  import ifq_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input wire logic clk,
  input wire logic pcrst,
  ifq_if.master    bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  ifq_state_t    r_state;
  logic [31:0]   r_fetch_pc;
  logic          r_imem_req;
  logic [31:0]   r_imem_addr;
  logic [63:0]   r_last;

  logic [63:0]   w_head;
  logic [CW-1:0] w_count;
  logic          w_full;
  logic          w_empty;
  logic          w_redirect;
  logic          w_push;
  logic          w_pop;
  logic [31:0]   w_redir_pc;
  logic [31:0]   w_pc_after;
  logic [CW-1:0] w_count_next;
  logic          w_issue_ok;
  logic          w_unused;

  assign w_redir_pc = {bus.redirect_pc[31:2], 2'b00};
  assign w_unused   = ^bus.redirect_pc[1:0];

`ifdef IFQ_JUMP_PREDECODE_EN
  logic w_head_is_j;
  assign w_head_is_j = !w_empty && (w_head[31:26] == OP_J);
  // decode re-issuing the jump we already followed must not discard the prefetched target
  assign w_redirect  = bus.redirect &&
                       !(w_head_is_j && (w_redir_pc == jump_target(w_head[63:32], w_head[25:0])));
  assign w_pc_after  = (bus.imem_rdata[31:26] == OP_J) ?
                       jump_target(r_fetch_pc, bus.imem_rdata[25:0]) : r_fetch_pc + PC_STEP;
`else
  assign w_redirect  = bus.redirect;
  assign w_pc_after  = r_fetch_pc + PC_STEP;
`endif

  assign w_push       = (r_state == WAIT) && bus.imem_rvalid && !w_redirect && !w_full;
  assign w_pop        = !w_empty && bus.inst_ready && !w_redirect;
  assign w_count_next = w_count + CW'(w_push) - CW'(w_pop);
  assign w_issue_ok   = (w_count_next < CW'(DEPTH));

  ifq_fifo #(.DEPTH(DEPTH), .WIDTH(64)) u_fifo (
    .clk     (clk),
    .rst     (pcrst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_redirect),
    .i_data  ({r_fetch_pc, bus.imem_rdata}),
    .o_data  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign bus.imem_req   = r_imem_req;
  assign bus.imem_addr  = r_imem_addr;
  assign bus.inst_valid = !w_empty;
  assign bus.inst       = w_empty ? r_last[31:0]  : w_head[31:0];
  assign bus.inst_pc    = w_empty ? r_last[63:32] : w_head[63:32];

  always_ff @(posedge clk) begin
    if (pcrst)         r_last <= '0;
    else if (!w_empty) r_last <= w_head;
  end

  // Request is registered: issuing on the response edge keeps the one-cycle gap minimal
  always_ff @(posedge clk) begin
    if (pcrst) begin
      r_state     <= IDLE;
      r_fetch_pc  <= RESET_PC;
      r_imem_req  <= 1'b0;
      r_imem_addr <= '0;
    end else begin
      r_imem_req <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_redirect) begin
            r_fetch_pc <= w_redir_pc;
          end else if (w_issue_ok) begin
            r_imem_req  <= 1'b1;
            r_imem_addr <= r_fetch_pc;
            r_state     <= WAIT;
          end
        end
        WAIT: begin
          if (w_redirect) begin
            r_fetch_pc <= w_redir_pc;
            r_state    <= bus.imem_rvalid ? IDLE : DISCARD;
          end else if (bus.imem_rvalid) begin
            r_fetch_pc <= w_pc_after;
            if (w_issue_ok) begin
              r_imem_req  <= 1'b1;
              r_imem_addr <= w_pc_after;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        DISCARD: begin
          if (w_redirect)      r_fetch_pc <= w_redir_pc;
          if (bus.imem_rvalid) r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_inst_fetch_queue : directed table, corner sequences and random traffic |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_inst_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef IFQ_JUMP_PREDECODE_EN
  localparam bit PRED = 1'b1;
`else
  localparam bit PRED = 1'b0;
`endif

  logic clk = 1'b0;
  logic pcrst;
  always #5 clk = ~clk;

  ifq_if bus();
  inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .pcrst (pcrst),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // memory responder and manual response override
  logic        rsp_v, man_v, rsp_clear, jmode;
  logic [31:0] rsp_d, man_d, paddr;
  int          mem_lat, pend;
  assign bus.imem_rvalid = rsp_v | man_v;
  assign bus.imem_rdata  = man_v ? man_d : rsp_d;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (jmode && a == 32'h0) return 32'h0800_0010;
    return {6'b100011, a[25:0]};
  endfunction

  initial begin
    rsp_v = 1'b0; rsp_d = '0; pend = 0; paddr = '0;
    forever begin
      @(posedge clk); #2;
      rsp_v = 1'b0;
      if (rsp_clear) pend = 0;
      else if (pend > 0) begin
        pend--;
        if (pend == 0) begin rsp_v = 1'b1; rsp_d = mem_word(paddr); end
      end
      if (bus.imem_req && !rsp_clear) begin pend = mem_lat; paddr = bus.imem_addr; end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  // reference model: ordered queue of fetched words plus one-request bookkeeping
  typedef struct { logic [31:0] inst; logic [31:0] pc; } ent_t;
  ent_t        mq[$];
  logic [31:0] mpc;
  bit          outst, stale;
  int          req_seen = 0;

  function automatic logic [31:0] jtgt(input logic [31:0] pc, input logic [31:0] w);
    logic [31:0] p4;
    p4 = pc + 32'd4;
    return {p4[31:28], w[25:0], 2'b00};
  endfunction

  function automatic bit is_j(input logic [31:0] w);
    return PRED && (w[31:26] == 6'b000010);
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (pcrst) begin
        mq.delete(); mpc = RESET_PC; outst = 0; stale = 0;
      end else begin
        bit eff;
        logic [31:0] rp;
        rp  = bus.redirect_pc & ~32'd3;
        eff = bus.redirect && !(mq.size() > 0 && is_j(mq[0].inst) && rp == jtgt(mq[0].pc, mq[0].inst));
        if (eff) begin
          mq.delete(); mpc = rp;
          if (outst && bus.imem_rvalid) begin outst = 0; stale = 0; end
          else if (outst) stale = 1;
        end else begin
          if (bus.inst_ready && mq.size() > 0) void'(mq.pop_front());
          if (bus.imem_rvalid && outst) begin
            outst = 0;
            if (stale) stale = 0;
            else begin
              mq.push_back('{inst: bus.imem_rdata, pc: mpc});
              mpc = is_j(bus.imem_rdata) ? jtgt(mpc, bus.imem_rdata) : mpc + 32'd4;
            end
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("m_inst_valid", 32'(bus.inst_valid), 32'(mq.size() > 0));
      if (mq.size() > 0 && bus.inst_valid) begin
        chk("m_inst", bus.inst, mq[0].inst);
        chk("m_inst_pc", bus.inst_pc, mq[0].pc);
      end
      if (bus.imem_req) begin
        chk("m_req_addr", bus.imem_addr, mpc);
        chk("m_one_outstanding", 32'(outst), 32'd0);
        chk("m_space_at_issue", 32'(mq.size() < DEPTH), 32'd1);
        outst = 1; stale = 0; req_seen++;
      end
    end
  end

  typedef struct {
    int          lat;
    bit          ready_pre;
    logic [31:0] rp;
    logic [31:0] exp_first;
    logic [31:0] exp_second;
  } vec_t;
  vec_t vt[4];

  logic [31:0] a, a1, a2, vpc;
  bit          got1, got2, gotv;
  int          nr, nv, r0;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int n);
    pcrst = 1'b1; rsp_clear = 1'b1; man_v = 1'b0;
    bus.redirect = 1'b0; bus.inst_ready = 1'b0;
    repeat (n) tick();
    pcrst = 1'b0; rsp_clear = 1'b0;
  endtask

  task automatic wait_req(input string nm, output logic [31:0] addr);
    int n = 0;
    while (!bus.imem_req && n < 60) begin tick(); n++; end
    addr = bus.imem_addr;
    if (!bus.imem_req) begin
      checks++; failures++;
      $display("FAIL %s: imem_req timeout actual=0 required=1", nm);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{5, 1'b1, 32'h0000_0040, 32'h0000_0040, 32'h0000_0044};
    vt[1] = '{1, 1'b0, 32'h0000_0040, 32'h0000_0040, 32'h0000_0044};
    vt[2] = '{3, 1'b0, 32'h0000_0043, 32'h0000_0040, 32'h0000_0044};
    vt[3] = '{2, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000};

    pcrst = 1'b1; rsp_clear = 1'b1; man_v = 1'b0; man_d = '0; jmode = 1'b0; mem_lat = 1;
    bus.inst_ready = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0;

    // reset values, then sequential stream with latency 1
    do_reset(3);
    chk("rst_imem_req", 32'(bus.imem_req), 32'd0);
    chk("rst_imem_addr", bus.imem_addr, 32'd0);
    chk("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
    chk("rst_inst", bus.inst, 32'd0);
    chk("rst_inst_pc", bus.inst_pc, 32'd0);
    bus.inst_ready = 1'b1;
    nr = 0; nv = 0;
    for (int n = 0; n < 80 && (nr < 3 || nv < 3); n++) begin
      if (bus.imem_req && nr < 3) begin chk("t1_req_addr", bus.imem_addr, 32'(nr * 4)); nr++; end
      if (bus.inst_valid && nv < 3) begin chk("t1_inst_pc", bus.inst_pc, 32'(nv * 4)); nv++; end
      tick();
    end
    chk("t1_progress", 32'(nr + nv), 32'd6);

    // full queue back-pressure
    do_reset(2);
    mem_lat = 2; bus.inst_ready = 1'b0; nr = 0;
    repeat (40) begin if (bus.imem_req) nr++; tick(); end
    chk("t2_req_count_full", 32'(nr), 32'd4);
    chk("t2_full_valid", 32'(bus.inst_valid), 32'd1);
    bus.inst_ready = 1'b1; tick(); bus.inst_ready = 1'b0;
    chk("t2_req_after_pop", 32'(bus.imem_req), 32'd1);
    chk("t2_addr_after_pop", bus.imem_addr, 32'h10);
    tick(); nr = 0;
    repeat (20) begin if (bus.imem_req) nr++; tick(); end
    chk("t2_no_extra_req", 32'(nr), 32'd0);

    // redirect table: redirect the cycle after the request for 0x8 is seen
    for (int i = 0; i < 4; i++) begin
      do_reset(2);
      mem_lat = vt[i].lat; bus.inst_ready = vt[i].ready_pre;
      wait_req("tv_req0", a); tick();
      wait_req("tv_req1", a); tick();
      wait_req("tv_req2", a);
      chk("tv_pre_addr", a, 32'h8);
      tick();
      bus.redirect = 1'b1; bus.redirect_pc = vt[i].rp; bus.inst_ready = 1'b1;
      tick();
      bus.redirect = 1'b0;
      chk("tv_flush", 32'(bus.inst_valid), 32'd0);
      got1 = 0; got2 = 0; gotv = 0; a1 = '0; a2 = '0; vpc = '0;
      for (int n = 0; n < 80 && !(got2 && gotv); n++) begin
        if (bus.inst_valid && !gotv) begin gotv = 1; vpc = bus.inst_pc; end
        if (bus.imem_req) begin
          if (!got1) begin got1 = 1; a1 = bus.imem_addr; end
          else if (!got2) begin got2 = 1; a2 = bus.imem_addr; end
        end
        tick();
      end
      chk("tv_seen_all", {29'd0, got1, got2, gotv}, 32'd7);
      chk("tv_first_addr", a1, vt[i].exp_first);
      chk("tv_first_inst_pc", vpc, vt[i].exp_first);
      chk("tv_second_addr", a2, vt[i].exp_second);
    end

    // reset held mid-request, stray response right after release
    do_reset(2);
    mem_lat = 6; bus.inst_ready = 1'b1;
    wait_req("t5_req0", a); tick(); tick();
    pcrst = 1'b1; rsp_clear = 1'b1; tick(); tick();
    pcrst = 1'b0; rsp_clear = 1'b0; man_v = 1'b1; man_d = 32'hDEAD_BEEF;
    tick();
    man_v = 1'b0;
    chk("t5_late_ignored", 32'(bus.inst_valid), 32'd0);
    wait_req("t5_req", a);
    chk("t5_first_addr", a, RESET_PC);
    for (int n = 0; n < 40 && !bus.inst_valid; n++) tick();
    chk("t5_first_inst", bus.inst, mem_word(RESET_PC));

    // jump word at 0x0
    do_reset(2);
    jmode = 1'b1; mem_lat = 1; bus.inst_ready = 1'b0;
    wait_req("t6_req0", a); tick();
    wait_req("t6_req1", a);
    chk("t6_next_addr", a, PRED ? 32'h40 : 32'h4);
    repeat (10) tick();
    chk("t6_head_is_j", bus.inst, 32'h0800_0010);
    bus.redirect = 1'b1; bus.redirect_pc = 32'h40; bus.inst_ready = 1'b1;
    tick();
    bus.redirect = 1'b0; bus.inst_ready = 1'b0;
    chk("t6_no_flush", 32'(bus.inst_valid), 32'(PRED));
    for (int n = 0; n < 40 && !bus.inst_valid; n++) tick();
    chk("t6_after_j_pc", bus.inst_pc, 32'h40);
    jmode = 1'b0;

    // random traffic against the model
    do_reset(2);
    r0 = req_seen;
    for (int n = 0; n < 2000; n++) begin
      mem_lat          = $urandom_range(1, 4);
      bus.inst_ready   = ($urandom_range(0, 3) != 0);
      bus.redirect     = ($urandom_range(0, 29) == 0);
      bus.redirect_pc  = (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(0, 3));
      tick();
    end
    bus.redirect = 1'b0;
    chk("rand_progress", 32'(req_seen - r0 >= 200), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
